// File: rtl/phase_timer.sv
// Loadable, prescaled down-counter for traffic-light phase durations.
// The phase sequencer loads a duration with start, and the timer counts it
// down in steps of PRESCALE clocks. The timer either fires a single done
// pulse and parks in EXPIRED, or reloads and keeps running (auto_reload).
// All outputs come straight from registers.
module phase_timer #(
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 1,
    parameter int DEFAULT_LOAD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             busy,
    output logic             expired
);

    // Prescaler is at least one bit wide so PRESCALE=1 still synthesises cleanly.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] LOAD_RST   = WIDTH'(DEFAULT_LOAD);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] reload_q,  reload_d;
    logic [PW-1:0]    presc_q,   presc_d;
    logic             done_q,    done_d;
    logic             busy_q,    busy_d;
    logic             expired_q, expired_d;

    logic start_ok;
    logic running;

    // A start carrying a zero length is not a command at all; the timer then
    // carries on exactly as if start were low.
    assign start_ok = start && (load_val != '0);
    assign running  = (state_q == S_RUN) || (state_q == S_PAUSED);

    // Next-state logic: stop beats start, start beats pause, pause beats a step.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        done_d   = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            count_d = reload_q;
            presc_d = '0;
        end else if (start_ok) begin
            // Retrigger also lands here, which cancels any expiry due this edge.
            reload_d = load_val;
            count_d  = load_val;
            presc_d  = '0;
            state_d  = S_RUN;
        end else if (running) begin
            if (pause) begin
                // Freeze count and prescaler mid-period.
                state_d = S_PAUSED;
            end else begin
                // Leaving PAUSED counts this edge, so a pause costs exactly
                // as many cycles as pause was high.
                state_d = S_RUN;
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (count_q == WIDTH'(1)) begin
                        done_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = S_EXPIRED;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        end

        busy_d    = (state_d == S_RUN) || (state_d == S_PAUSED);
        expired_d = (state_d == S_EXPIRED);
    end

    // State and registered outputs, with asynchronous reset to the idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= LOAD_RST;
            reload_q  <= LOAD_RST;
            presc_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign expired = expired_q;

endmodule
